// File: rtl/dense_train_ctrl_pkg.sv
// Shared definitions for the dense-layer training sequencer: state encoding,
// default watchdog limit and the phase identifiers shared with the top-level trainer.
package dense_train_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ZERO     = 3'd1,
        ST_FWD_WAIT = 3'd2,
        ST_FWD      = 3'd3,
        ST_BWD_WAIT = 3'd4,
        ST_BWD      = 3'd5,
        ST_UPD      = 3'd6,
        ST_ERR      = 3'd7
    } state_t;

    localparam int TIMEOUT_DEFAULT = 4096;

    localparam logic [2:0] PH_NONE      = 3'd0;
    localparam logic [2:0] PH_ZERO_GRAD = 3'd1;
    localparam logic [2:0] PH_FORWARD   = 3'd2;
    localparam logic [2:0] PH_LOAD_BWD  = 3'd3;
    localparam logic [2:0] PH_BACKWARD  = 3'd4;
    localparam logic [2:0] PH_UPDATE    = 3'd5;

    // States in which a layer phase is running and the watchdog must count.
    function automatic logic is_timed(input state_t s);
        logic r;
        case (s)
            ST_ZERO, ST_FWD, ST_BWD, ST_UPD: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dense_train_ctrl_watchdog.sv
// Phase watchdog: counts cycles spent in a running phase and flags expiry on
// the cycle the count reaches the limit. Reusable by other layer controllers.
module train_watchdog #(
    parameter int TIMEOUT = 4096,
    parameter int TMO_W   = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] cnt_r;
    logic [TMO_W-1:0] count_s;

    // clear marks the first cycle of a phase, which already counts as cycle 0.
    assign count_s = clear ? {TMO_W{1'b0}} : cnt_r;
    assign expired = enable && (count_s == LIMIT);

    // Cycle counter, saturating at the limit so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {TMO_W{1'b0}};
        end else if (!enable) begin
            cnt_r <= {TMO_W{1'b0}};
        end else if (clear) begin
            cnt_r <= TMO_W'(1);
        end else if (cnt_r != LIMIT) begin
            cnt_r <= cnt_r + TMO_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/dense_train_ctrl.sv
// Mini-batch sequencer for one dense layer: zero_grad, per-sample forward /
// load / backward, then update, with a per-phase watchdog.
module dense_train_ctrl
    import dense_train_ctrl_pkg::*;
#(
    parameter int BATCH_W = 8,
    parameter int STEP_W  = 16,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int TMO_W   = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [BATCH_W-1:0] batch_size,
    input  logic [STEP_W-1:0]  num_steps,
    input  logic               fwd_data_ready,
    input  logic               bwd_data_ready,
    input  logic               valid_zero_grad,
    input  logic               valid_forward,
    input  logic               valid_backward,
    input  logic               valid_update,
    output logic               zero_grad,
    output logic               run_forward,
    output logic               run_backward,
    output logic               update,
    output logic               load_backward,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [BATCH_W-1:0] sample_idx,
    output logic [STEP_W-1:0]  step_idx,
    output logic [2:0]         state_o
);

    state_t             state_r;
    logic               zero_grad_r, run_forward_r, run_backward_r, update_r, load_backward_r;
    logic               busy_r, done_r, error_r, wd_clear_r;
    logic [BATCH_W-1:0] sample_idx_r, batch_r;
    logic [STEP_W-1:0]  step_idx_r, steps_r;
    logic               phase_valid_s, expired_s;

    train_watchdog #(.TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear_r),
        .enable  (is_timed(state_r)),
        .expired (expired_s)
    );

    // Completion flag belonging to the phase currently running; others are ignored.
    always_comb begin
        phase_valid_s = 1'b0;
        case (state_r)
            ST_ZERO: phase_valid_s = valid_zero_grad;
            ST_FWD:  phase_valid_s = valid_forward;
            ST_BWD:  phase_valid_s = valid_backward;
            ST_UPD:  phase_valid_s = valid_update;
            default: phase_valid_s = 1'b0;
        endcase
    end

    // Sequencer FSM with all outputs registered; abort beats the watchdog, which beats normal flow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            zero_grad_r     <= 1'b0;
            run_forward_r   <= 1'b0;
            run_backward_r  <= 1'b0;
            update_r        <= 1'b0;
            load_backward_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            error_r         <= 1'b0;
            wd_clear_r      <= 1'b0;
            sample_idx_r    <= {BATCH_W{1'b0}};
            step_idx_r      <= {STEP_W{1'b0}};
            batch_r         <= {BATCH_W{1'b0}};
            steps_r         <= {STEP_W{1'b0}};
        end else if (abort) begin
            state_r         <= ST_IDLE;
            zero_grad_r     <= 1'b0;
            run_forward_r   <= 1'b0;
            run_backward_r  <= 1'b0;
            update_r        <= 1'b0;
            load_backward_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            error_r         <= 1'b0;
            wd_clear_r      <= 1'b0;
            sample_idx_r    <= {BATCH_W{1'b0}};
            step_idx_r      <= {STEP_W{1'b0}};
        end else if (expired_s && !phase_valid_s) begin
            state_r         <= ST_ERR;
            zero_grad_r     <= 1'b0;
            run_forward_r   <= 1'b0;
            run_backward_r  <= 1'b0;
            update_r        <= 1'b0;
            load_backward_r <= 1'b0;
            busy_r          <= 1'b1;
            done_r          <= 1'b0;
            error_r         <= 1'b1;
            wd_clear_r      <= 1'b0;
        end else begin
            done_r          <= 1'b0;
            load_backward_r <= 1'b0;
            wd_clear_r      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                    if (start) begin
                        batch_r      <= batch_size;
                        steps_r      <= num_steps;
                        error_r      <= 1'b0;
                        sample_idx_r <= {BATCH_W{1'b0}};
                        step_idx_r   <= {STEP_W{1'b0}};
                        if (batch_size == {BATCH_W{1'b0}} || num_steps == {STEP_W{1'b0}}) begin
                            done_r <= 1'b1;
                        end else begin
                            state_r     <= ST_ZERO;
                            zero_grad_r <= 1'b1;
                            busy_r      <= 1'b1;
                            wd_clear_r  <= 1'b1;
                        end
                    end
                end
                ST_ZERO: begin
                    if (valid_zero_grad) begin
                        zero_grad_r <= 1'b0;
                        state_r     <= ST_FWD_WAIT;
                    end
                end
                ST_FWD_WAIT: begin
                    if (fwd_data_ready) begin
                        run_forward_r <= 1'b1;
                        state_r       <= ST_FWD;
                        wd_clear_r    <= 1'b1;
                    end
                end
                ST_FWD: begin
                    if (valid_forward) begin
                        run_forward_r <= 1'b0;
                        state_r       <= ST_BWD_WAIT;
                    end
                end
                ST_BWD_WAIT: begin
                    // The load pulse occupies one cycle of its own so backward always follows it.
                    if (load_backward_r) begin
                        run_backward_r <= 1'b1;
                        state_r        <= ST_BWD;
                        wd_clear_r     <= 1'b1;
                    end else if (bwd_data_ready) begin
                        load_backward_r <= 1'b1;
                    end
                end
                ST_BWD: begin
                    if (valid_backward) begin
                        run_backward_r <= 1'b0;
                        if (sample_idx_r == batch_r - BATCH_W'(1)) begin
                            sample_idx_r <= {BATCH_W{1'b0}};
                            update_r     <= 1'b1;
                            state_r      <= ST_UPD;
                            wd_clear_r   <= 1'b1;
                        end else begin
                            sample_idx_r <= sample_idx_r + BATCH_W'(1);
                            state_r      <= ST_FWD_WAIT;
                        end
                    end
                end
                ST_UPD: begin
                    if (valid_update) begin
                        update_r <= 1'b0;
                        if (step_idx_r == steps_r - STEP_W'(1)) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            step_idx_r  <= step_idx_r + STEP_W'(1);
                            zero_grad_r <= 1'b1;
                            state_r     <= ST_ZERO;
                            wd_clear_r  <= 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    busy_r  <= 1'b1;
                    error_r <= 1'b1;
                end
                default: begin
                    state_r        <= ST_IDLE;
                    zero_grad_r    <= 1'b0;
                    run_forward_r  <= 1'b0;
                    run_backward_r <= 1'b0;
                    update_r       <= 1'b0;
                    busy_r         <= 1'b0;
                end
            endcase
        end
    end

    assign zero_grad     = zero_grad_r;
    assign run_forward   = run_forward_r;
    assign run_backward  = run_backward_r;
    assign update        = update_r;
    assign load_backward = load_backward_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;
    assign sample_idx    = sample_idx_r;
    assign step_idx      = step_idx_r;
    assign state_o       = state_r;

endmodule

// File: doc/dense_train_ctrl.md
Name: dense_train_ctrl

Overview:
- Sequences one dense training layer through mini-batch steps: zero_grad, then per sample run_forward / load_backward / run_backward, then update.
- Drives the layer's level-style run strobes and terminates each phase on the layer's matching valid_* flag.
- Sits between the top-level training FSM / host registers and the dense layer instance.
- Counts samples per batch and steps per run, and flags a stuck phase with a watchdog.

Parameters:
- BATCH_W, 8, width of batch_size and sample_idx
- STEP_W, 16, width of num_steps and step_idx
- TIMEOUT, 4096, max cycles a layer phase may run before error
- TMO_W, 13, watchdog counter width, must satisfy 2^TMO_W > TIMEOUT

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle request to begin a run; sampled only in IDLE
- abort  in  1  return to IDLE from any state
- batch_size  in  BATCH_W  samples per step; latched at start
- num_steps  in  STEP_W  optimizer steps per run; latched at start
- fwd_data_ready  in  1  next sample's d_forward is stable at the layer input
- bwd_data_ready  in  1  loss gradient d_backward for the current sample is stable
- valid_zero_grad, valid_forward, valid_backward, valid_update  in  1 each  phase-complete flags from the layer
- zero_grad, run_forward, run_backward, update  out  1 each  phase strobes, held high until the matching valid is seen
- load_backward  out  1  one-cycle pulse; latches the forward input buffer for backward
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at normal completion
- error  out  1  sticky watchdog flag; cleared by start or abort
- sample_idx  out  BATCH_W  current sample within the batch
- step_idx  out  STEP_W  current step
- state_o  out  3  encoded state, for debug

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Counters 0.
  - Latched config 0.
- All outputs are registered. No combinational path from inputs to strobes.
- State encoding: IDLE=0, ZERO=1, FWD_WAIT=2, FWD=3, BWD_WAIT=4, BWD=5, UPD=6, ERR=7.
- IDLE:
  - start at cycle t: latch config, clear error, sample_idx=0, step_idx=0.
  - If batch_size==0 or num_steps==0: done=1 at t+1, stay IDLE, no strobes.
  - Otherwise enter ZERO at t+1 with zero_grad=1.
- ZERO: on valid_zero_grad=1 at cycle k, zero_grad=0 at k+1 and state FWD_WAIT.
- FWD_WAIT: on fwd_data_ready=1, run_forward=1 the next cycle and state FWD.
- FWD: on valid_forward=1, run_forward=0 the next cycle and state BWD_WAIT.
- BWD_WAIT:
  - On bwd_data_ready=1 at cycle k: load_backward=1 for cycle k+1 only.
  - run_backward=1 from k+2 and state BWD.
  - The load always precedes backward by exactly one cycle.
- BWD: on valid_backward=1, run_backward=0 the next cycle.
  - If sample_idx==batch_size-1: sample_idx=0, update=1, state UPD.
  - Otherwise: sample_idx+1, state FWD_WAIT.
- UPD: on valid_update=1, update=0 the next cycle.
  - If step_idx==num_steps-1: done=1 for one cycle, state IDLE.
  - Otherwise: step_idx+1, zero_grad=1, state ZERO.
- Never more than one of zero_grad/run_forward/run_backward/update/load_backward high in the same cycle.
- Watchdog:
  - Counter clears on entry to ZERO, FWD, BWD and UPD, and increments each cycle in those states.
  - On reaching TIMEOUT: all strobes go 0 the next cycle, error=1, state ERR.
  - FWD_WAIT and BWD_WAIT have no timeout.
- ERR: holds with error=1 and busy=1. Only abort (to IDLE, error cleared) leaves it. start is ignored in ERR.
- abort:
  - Any state goes to IDLE the next cycle; strobes 0, counters 0, error 0, no done.
  - abort has priority over start and over a simultaneous valid.
- start outside IDLE is ignored. Latched config does not change mid-run.
- A valid_* input that does not match the current phase is ignored.

Decomposition:
- Shared package/header (consts_train.vh):
  - state encodings
  - default TIMEOUT
  - a phase-id localparam set reused by the top-level trainer
- One natural sub-module: train_watchdog (clear, enable, TIMEOUT compare, expired flag), reusable for the other layers' controllers.
- Everything else stays in one file.

Test Plan:
- batch_size=2, num_steps=1, layer model returns valid 3 cycles after each strobe rises, data_ready always 1 -> strobe order zero_grad, fwd, load, bwd, fwd, load, bwd, update; load_backward pulses exactly twice, each 1 cycle before run_backward rises; exactly one done; busy falls with done.
- batch_size=1, num_steps=3 -> zero_grad and update asserted 3 times each; step_idx reads 0, 1, 2; done once after the third valid_update.
- batch_size=0, num_steps=5 -> done the cycle after start; no strobe ever high; busy stays 0.
- valid_backward never asserted -> run_backward high for 4096 cycles, then low; error=1, state_o=7; abort -> IDLE, error=0 next cycle.
- abort asserted in the same cycle as valid_forward during FWD -> IDLE next cycle, no BWD_WAIT entry, no done.
- start pulsed during BWD with batch_size input changed to 9 -> ignored; run finishes with the original batch size and produces a single done.
